count_seq_checker: RTL and testbench
====================================

Name: count_seq_checker

Overview:
- Sits directly downstream of the 4-bit free-running counter (counter4bit) and consumes its count output.
- The counter under test is required to increment by exactly 1, modulo 2^WIDTH, on every clock after its reset releases.
- This block acquires lock onto that sequence, then flags every break in it.
- It also keeps saturating wrap and error statistics for the bench and for system status.

Parameters:
- WIDTH, 4: width of the monitored count bus.
- LOCK_CNT, 2: consecutive correct increments required to assert locked (legal range 1 to 15).
- STAT_W, 8: width of the wrap_cnt and err_cnt statistics counters.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst  input  1  synchronous, active-high reset.
- en  input  1  monitoring enable.
- clear  input  1  single-cycle synchronous clear of statistics and sticky flag.
- count  input  WIDTH  counter value being monitored.
- locked  output  1  block is tracking a valid sequence.
- err_pulse  output  1  one-cycle strobe for each detected sequence break.
- err_sticky  output  1  set on any error; cleared only by clear or rst.
- wrap_cnt  output  STAT_W  number of legal max-to-0 wraps while locked; saturating.
- err_cnt  output  STAT_W  number of errors detected while locked; saturating.

Behaviour:
- One clock domain.
- Reset is synchronous and active-high.
- All outputs are registered.
- rst has priority over every other input.
- Reset values:
  - state = IDLE
  - prev_q = 0
  - good_run = 0
  - locked = 0
  - err_pulse = 0
  - err_sticky = 0
  - wrap_cnt = 0
  - err_cnt = 0
- "Match" means count == prev_q + 1, computed modulo 2^WIDTH. A held value counts as a mismatch.
- prev_q <= count on every edge where en = 1.
- State IDLE:
  - en = 1 -> ACQUIRE; good_run <= 0.
- State ACQUIRE:
  - Match -> good_run + 1. When that value reaches LOCK_CNT: go to LOCKED, locked <= 1.
  - Mismatch -> good_run <= 0. No error is recorded in ACQUIRE.
- State LOCKED:
  - Match with prev_q = all-ones and count = 0 -> wrap_cnt + 1.
  - Mismatch:
    - err_pulse <= 1 for exactly one cycle.
    - err_cnt + 1; err_sticky <= 1.
    - locked <= 0; go to ACQUIRE; good_run <= 0.
    - prev_q resyncs to count.
  - A mismatch into 0 (counter reset mid-run) is an error, not a wrap.
- en = 0 in any state:
  - Next state IDLE; locked <= 0.
  - err_pulse is not raised.
  - Statistics and err_sticky are held.
- Latency: err_pulse, locked and the statistics update on the edge that samples the offending or qualifying count.
- Statistics counters saturate at 2^STAT_W - 1 and never wrap.
- clear:
  - Zeroes wrap_cnt, err_cnt and err_sticky.
  - Does not affect state, locked or prev_q.
  - clear in the same cycle as an event: clear is applied first, then the event. The result is cnt = 1, and err_sticky = 1 for an error.
- err_pulse defaults to 0 on every cycle not listed above.

Test Plan:
- Counter reset and count/en sequencing (LOCK_CNT = 2): release counter rst; checker en = 1 from the edge sampling count = 0; count = 0, 1, 2 -> locked = 1 after the edge sampling 2; err_cnt = 0; err_pulse never high.
- Wrap counting: after lock at count = 2, run 40 more cycles (counts 3 through 42 absolute) -> wrap_cnt = 2, err_cnt = 0, locked stays 1.
- Held value: force count sequence 6, 7, 7, 8, 9 while locked:
  - The edge sampling the second 7 gives err_pulse = 1 for one cycle, err_cnt = 1, err_sticky = 1, locked = 0.
  - locked returns to 1 on the edge sampling 9.
- Counter reset mid-run: pulse counter rst so count goes 9 -> 0 -> err_cnt increments by 1, wrap_cnt unchanged, relock on 0, 1, 2.
- Clear behaviour:
  - clear asserted on the same edge as an error, with err_cnt previously 3 -> err_cnt = 1, err_sticky = 1.
  - Later clear alone -> err_cnt = 0, wrap_cnt = 0, err_sticky = 0, locked unaffected.
- Enable and reset:
  - en dropped while locked -> locked = 0 next edge; statistics held.
  - rst asserted mid-lock with en = 1 -> every output 0 after that edge; reacquisition needs LOCK_CNT + 1 samples after rst releases.

Source files
------------

// File: rtl/count_seq_checker_if.sv
// Bundle between a free-running counter monitor and its environment:
// controls and the monitored count in, lock/error status and statistics out.
interface count_seq_checker_if #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
);
    logic              en;
    logic              clear;
    logic [WIDTH-1:0]  count;
    logic              locked;
    logic              err_pulse;
    logic              err_sticky;
    logic [STAT_W-1:0] wrap_cnt;
    logic [STAT_W-1:0] err_cnt;

    modport master (
        output en, clear, count,
        input  locked, err_pulse, err_sticky, wrap_cnt, err_cnt
    );

    modport slave (
        input  en, clear, count,
        output locked, err_pulse, err_sticky, wrap_cnt, err_cnt
    );
endinterface

// File: rtl/count_seq_checker.sv
// Locks onto a +1 (mod 2^WIDTH) count sequence, flags every break once locked,
// and keeps saturating wrap/error statistics.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int STAT_W   = 8
) (
    input logic                  clk,
    input logic                  rst,
    count_seq_checker_if.slave   bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic [1:0]        state_r,      state_s;
    logic [WIDTH-1:0]  prev_r,       prev_s;
    logic [3:0]        good_run_r,   good_run_s;
    logic              locked_r,     locked_s;
    logic              err_pulse_r,  err_pulse_s;
    logic              err_sticky_r, err_sticky_s;
    logic [STAT_W-1:0] wrap_cnt_r,   wrap_cnt_s;
    logic [STAT_W-1:0] err_cnt_r,    err_cnt_s;
    logic              match_s;
    logic              wrap_hit_s;
    logic [3:0]        run_inc_s;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == {STAT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Sequence comparison against the previously sampled count
    assign match_s    = (bus.count == (prev_r + {{(WIDTH-1){1'b0}}, 1'b1}));
    assign wrap_hit_s = (prev_r == {WIDTH{1'b1}});
    assign run_inc_s  = good_run_r + 4'd1;

    // Next-state logic; clear is folded in first so a same-cycle event lands on zero
    always_comb begin
        state_s      = state_r;
        prev_s       = prev_r;
        good_run_s   = good_run_r;
        locked_s     = locked_r;
        err_pulse_s  = 1'b0;
        if (bus.clear) begin
            err_sticky_s = 1'b0;
            wrap_cnt_s   = {STAT_W{1'b0}};
            err_cnt_s    = {STAT_W{1'b0}};
        end else begin
            err_sticky_s = err_sticky_r;
            wrap_cnt_s   = wrap_cnt_r;
            err_cnt_s    = err_cnt_r;
        end

        if (!bus.en) begin
            state_s  = IDLE;
            locked_s = 1'b0;
        end else begin
            prev_s = bus.count;
            case (state_r)
                IDLE: begin
                    state_s    = ACQUIRE;
                    good_run_s = 4'd0;
                end
                ACQUIRE: begin
                    if (match_s) begin
                        good_run_s = run_inc_s;
                        if (run_inc_s == 4'(LOCK_CNT)) begin
                            state_s  = LOCKED;
                            locked_s = 1'b1;
                        end else begin
                            state_s  = ACQUIRE;
                        end
                    end else begin
                        good_run_s = 4'd0;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        if (wrap_hit_s) begin
                            wrap_cnt_s = sat_inc(wrap_cnt_s);
                        end else begin
                            wrap_cnt_s = wrap_cnt_s;
                        end
                    end else begin
                        // A jump back to 0 lands here too: it is a break, not a wrap
                        err_pulse_s  = 1'b1;
                        err_sticky_s = 1'b1;
                        err_cnt_s    = sat_inc(err_cnt_s);
                        locked_s     = 1'b0;
                        state_s      = ACQUIRE;
                        good_run_s   = 4'd0;
                    end
                end
                default: begin
                    state_s    = IDLE;
                    locked_s   = 1'b0;
                    good_run_s = 4'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            prev_r       <= {WIDTH{1'b0}};
            good_run_r   <= 4'd0;
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            err_sticky_r <= 1'b0;
            wrap_cnt_r   <= {STAT_W{1'b0}};
            err_cnt_r    <= {STAT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            prev_r       <= prev_s;
            good_run_r   <= good_run_s;
            locked_r     <= locked_s;
            err_pulse_r  <= err_pulse_s;
            err_sticky_r <= err_sticky_s;
            wrap_cnt_r   <= wrap_cnt_s;
            err_cnt_r    <= err_cnt_s;
        end
    end

    assign bus.locked     = locked_r;
    assign bus.err_pulse  = err_pulse_r;
    assign bus.err_sticky = err_sticky_r;
    assign bus.wrap_cnt   = wrap_cnt_r;
    assign bus.err_cnt    = err_cnt_r;
endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: directed vector table, saturation
// runs and randomized traffic against a behavioural model.
module tb_count_seq_checker;
    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int STAT_W   = 8;
    localparam int MODV     = 1 << WIDTH;
    localparam int STATMAX  = (1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    count_seq_checker_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) bus ();

    count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r; bit e; bit c; int v;
        bit lk; bit p; bit s; int w; int er;
    } vec_t;
    vec_t vecs[$];

    // Behavioural model: a run length of consecutive +1 steps since the last sample
    bit m_started, m_locked, m_pulse, m_sticky;
    int m_prev, m_run, m_wrap, m_err;

    task automatic model_step(input bit r, input bit e, input bit c, input int v);
        bit ok;
        if (r) begin
            m_started = 0; m_locked = 0; m_pulse = 0; m_sticky = 0;
            m_prev = 0; m_run = 0; m_wrap = 0; m_err = 0;
            return;
        end
        m_pulse = 0;
        if (c) begin
            m_wrap = 0; m_err = 0; m_sticky = 0;
        end
        if (!e) begin
            m_started = 0; m_locked = 0;
            return;
        end
        ok = (v == (m_prev + 1) % MODV);
        if (!m_started) begin
            m_started = 1; m_run = 0;
        end else if (m_locked) begin
            if (ok) begin
                if (v == 0 && m_wrap < STATMAX) m_wrap++;
            end else begin
                m_pulse = 1; m_sticky = 1; m_locked = 0; m_run = 0;
                if (m_err < STATMAX) m_err++;
            end
        end else if (ok) begin
            m_run++;
            if (m_run >= LOCK_CNT) m_locked = 1;
        end else begin
            m_run = 0;
        end
        m_prev = v;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit e, input bit c, input int v);
        rst       = r;
        bus.en    = e;
        bus.clear = c;
        bus.count = WIDTH'(v);
        @(posedge clk);
        model_step(r, e, c, v);
        #1;
        chk("m_locked",  int'(bus.locked),     int'(m_locked));
        chk("m_pulse",   int'(bus.err_pulse),  int'(m_pulse));
        chk("m_sticky",  int'(bus.err_sticky), int'(m_sticky));
        chk("m_wrap",    int'(bus.wrap_cnt),   m_wrap);
        chk("m_err",     int'(bus.err_cnt),    m_err);
    endtask

    task automatic add(input bit r, input bit e, input bit c, input int v,
                       input bit lk, input bit p, input bit s, input int w, input int er);
        vec_t t;
        t.r = r; t.e = e; t.c = c; t.v = v;
        t.lk = lk; t.p = p; t.s = s; t.w = w; t.er = er;
        vecs.push_back(t);
    endtask

    initial begin
        int cur;
        bit r, e, c;
        int v;
        bus.en = 1'b0; bus.clear = 1'b0; bus.count = '0;

        // rst  en clr cnt   lk p  s  wrap err
        add(1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   0, 0, 0, 0, 0);
        add(0, 1, 0, 2,   1, 0, 0, 0, 0);
        for (int i = 3; i <= 7; i++) add(0, 1, 0, i, 1, 0, 0, 0, 0);
        add(0, 1, 0, 7,   0, 1, 1, 0, 1);   // held value
        add(0, 1, 0, 8,   0, 0, 1, 0, 1);
        add(0, 1, 0, 9,   1, 0, 1, 0, 1);
        add(0, 1, 0, 0,   0, 1, 1, 0, 2);   // counter reset mid-run
        add(0, 1, 0, 1,   0, 0, 1, 0, 2);
        add(0, 1, 0, 2,   1, 0, 1, 0, 2);
        add(0, 1, 0, 3,   1, 0, 1, 0, 2);
        add(0, 1, 0, 5,   0, 1, 1, 0, 3);   // skip
        add(0, 1, 0, 6,   0, 0, 1, 0, 3);
        add(0, 1, 0, 7,   1, 0, 1, 0, 3);
        add(0, 1, 1, 9,   0, 1, 1, 0, 1);   // clear with error
        add(0, 1, 0, 10,  0, 0, 1, 0, 1);
        add(0, 1, 0, 11,  1, 0, 1, 0, 1);
        add(0, 1, 1, 12,  1, 0, 0, 0, 0);   // clear alone
        add(0, 1, 0, 14,  0, 1, 1, 0, 1);
        add(0, 1, 0, 15,  0, 0, 1, 0, 1);
        add(0, 1, 0, 0,   1, 0, 1, 0, 1);   // 15->0 while acquiring: no wrap
        add(0, 1, 0, 1,   1, 0, 1, 0, 1);
        add(0, 0, 0, 2,   0, 0, 1, 0, 1);   // en dropped
        add(0, 0, 0, 7,   0, 0, 1, 0, 1);
        add(0, 1, 0, 3,   0, 0, 1, 0, 1);
        add(0, 1, 0, 4,   0, 0, 1, 0, 1);
        add(0, 1, 0, 5,   1, 0, 1, 0, 1);
        add(1, 1, 0, 6,   0, 0, 0, 0, 0);   // rst while locked
        add(0, 1, 0, 7,   0, 0, 0, 0, 0);
        add(0, 1, 0, 8,   0, 0, 0, 0, 0);
        add(0, 1, 0, 9,   1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].v);
            chk($sformatf("vec%0d_locked", i), int'(bus.locked),     int'(vecs[i].lk));
            chk($sformatf("vec%0d_pulse", i),  int'(bus.err_pulse),  int'(vecs[i].p));
            chk($sformatf("vec%0d_sticky", i), int'(bus.err_sticky), int'(vecs[i].s));
            chk($sformatf("vec%0d_wrap", i),   int'(bus.wrap_cnt),   vecs[i].w);
            chk($sformatf("vec%0d_err", i),    int'(bus.err_cnt),    vecs[i].er);
        end

        // Wrap counting from a fresh reset: absolute counts 0..42
        apply(1, 0, 0, 0);
        for (int i = 0; i <= 42; i++) apply(0, 1, 0, i % MODV);
        chk("wrap40_wrap",   int'(bus.wrap_cnt), 2);
        chk("wrap40_err",    int'(bus.err_cnt),  0);
        chk("wrap40_locked", int'(bus.locked),   1);
        // Clear on the same edge as a wrap
        for (int i = 43; i <= 47; i++) apply(0, 1, 0, i % MODV);
        apply(0, 1, 1, 0);
        chk("clr_wrap_wrap", int'(bus.wrap_cnt), 1);

        // Error counter saturation: repeated skip/relock
        cur = 0;
        for (int k = 0; k < 260; k++) begin
            cur = (cur + 2) % MODV; apply(0, 1, 0, cur);
            cur = (cur + 1) % MODV; apply(0, 1, 0, cur);
            cur = (cur + 1) % MODV; apply(0, 1, 0, cur);
        end
        chk("err_sat", int'(bus.err_cnt), STATMAX);

        // Wrap counter saturation
        for (int k = 0; k < 260 * MODV; k++) begin
            cur = (cur + 1) % MODV; apply(0, 1, 0, cur);
        end
        chk("wrap_sat", int'(bus.wrap_cnt), STATMAX);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 19) != 0);
            c = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, MODV - 1));
            else v = (cur + 1) % MODV;
            cur = v;
            apply(r, e, c, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
